// File: rtl/common.sv
// Core-wide architectural widths and address types.
package common;

  localparam int unsigned XLEN = 64;

  typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-register payloads shared between stages, plus fetch-stage helpers.
package pipes;

  import common::*;

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    addr_t           pc;
    logic [ILEN-1:0] raw_instr;
    logic            misalign;
  } fetch_data_t;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD
  } fetch_state_e;

  function automatic addr_t word_align(input addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word that the output register could not take.
module fetch_skid_buf
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  fetch_data_t din,
  output fetch_data_t dout
);

  fetch_data_t data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = '0;
    end else if (load) begin
      data_d = din;
    end else if (drain) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign dout = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding bus read, output register + skid.
// Optional FETCH_MISALIGN_CHECK_EN turns a misaligned PC into a flagged NOP instead of a bus read.
module fetch_stage
  import common::*, pipes::*;
#(
  parameter addr_t RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output addr_t           ireq_addr,
  input  logic            iresp_addr_ok,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  addr_t           redirect_pc,
  output fetch_data_t     out
);

  localparam addr_t PC_STEP = addr_t'(4);
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic RESET_REQ = (RESET_PC[1:0] == 2'b00);
`else
  localparam logic RESET_REQ = 1'b1;
`endif

  fetch_state_e state_q, state_d;
  logic         discard_q, discard_d;
  addr_t        pc_q, pc_d;
  logic         ireq_valid_q, ireq_valid_d;
  addr_t        ireq_addr_q, ireq_addr_d;
  fetch_data_t  out_q, out_d;

  fetch_data_t  word, skid_data;
  logic         resp, accept, out_free, word_v, mis_emit, req_ok;
  logic         skid_load, skid_drain, skid_clear;

  // A response completes the transaction either in WAIT or same-cycle with acceptance in REQ.
  assign resp     = ((state_q == FS_WAIT) && iresp_data_ok) ||
                    ((state_q == FS_REQ) && ireq_valid_q && iresp_addr_ok && iresp_data_ok);
  assign accept   = (state_q == FS_REQ) && ireq_valid_q && iresp_addr_ok && !iresp_data_ok;
  assign out_free = !out_q.valid || !stall;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_done_q, mis_done_d;

  assign mis_emit = (state_q == FS_REQ) && !ireq_valid_q && !redirect_valid &&
                    (pc_q[1:0] != 2'b00) && !mis_done_q;
  assign req_ok   = (pc_d[1:0] == 2'b00);

  // Remembers that the parked misaligned PC already produced its flagged NOP.
  always_comb begin
    mis_done_d = mis_done_q;
    if (redirect_valid) begin
      mis_done_d = 1'b0;
    end else if (mis_emit) begin
      mis_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_done_q <= 1'b0;
    end else begin
      mis_done_q <= mis_done_d;
    end
  end
`else
  assign mis_emit = 1'b0;
  assign req_ok   = 1'b1;
`endif

  assign word = '{valid: 1'b1, pc: pc_q,
                  raw_instr: (mis_emit ? NOP_INSTR : iresp_data), misalign: mis_emit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FS_REQ;
      discard_q    <= 1'b0;
      pc_q         <= RESET_PC;
      ireq_valid_q <= RESET_REQ;
      ireq_addr_q  <= word_align(RESET_PC);
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      pc_q         <= pc_d;
      ireq_valid_q <= ireq_valid_d;
      ireq_addr_q  <= ireq_addr_d;
      out_q        <= out_d;
    end
  end

  // Next state, PC and discard tracking; redirect outranks everything.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pc_d      = pc_q;
    word_v    = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (resp) begin
        discard_d = 1'b0;
        state_d   = FS_REQ;
      end else if (state_q == FS_HOLD) begin
        state_d = FS_REQ;
      end else if (accept) begin
        discard_d = 1'b1;
        state_d   = FS_WAIT;
      end else if ((state_q == FS_WAIT) || ireq_valid_q) begin
        discard_d = 1'b1;
      end
    end else if (resp) begin
      if (discard_q) begin
        discard_d = 1'b0;
        state_d   = FS_REQ;
      end else begin
        word_v  = 1'b1;
        pc_d    = pc_q + PC_STEP;
        state_d = out_free ? FS_REQ : FS_HOLD;
      end
    end else if (accept) begin
      state_d = FS_WAIT;
    end else if ((state_q == FS_HOLD) && !stall) begin
      state_d = FS_REQ;
    end else if (mis_emit) begin
      word_v  = 1'b1;
      state_d = out_free ? FS_REQ : FS_HOLD;
    end
  end

  // Output register, skid controls and the next bus request.
  always_comb begin
    out_d        = out_q;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;
    ireq_valid_d = ireq_valid_q;
    ireq_addr_d  = ireq_addr_q;
    if (redirect_valid) begin
      out_d      = '0;
      skid_clear = 1'b1;
    end else if ((state_q == FS_HOLD) && !stall) begin
      out_d      = skid_data;
      skid_drain = 1'b1;
    end else if (word_v) begin
      if (out_free) begin
        out_d = word;
      end else begin
        skid_load = 1'b1;
      end
    end else if (!stall) begin
      out_d = '0;
    end
    // A raised request is frozen until the bus takes it, even across a redirect.
    if (!(ireq_valid_q && !iresp_addr_ok)) begin
      ireq_valid_d = (state_d == FS_REQ) && req_ok;
      ireq_addr_d  = word_align(pc_d);
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .din   (word),
    .dout  (skid_data)
  );

  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = ireq_addr_q;
  assign out        = out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then a randomized bus/stall/redirect
// run scored against an instruction-stream model (sequential PCs, restart at redirect targets).
module tb_fetch_stage;

  import common::*;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  addr_t       ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  addr_t       redirect_pc;
  fetch_data_t out_w;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Randomized-phase model state
  addr_t       exp_pc;
  int unsigned delivered;
  logic        outst;
  addr_t       ost_addr;
  int unsigned dly;
  logic        p_req_v, p_aok, p_rd;
  addr_t       p_req_a;
  addr_t       tgt;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(64'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out            (out_w)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input addr_t pc,
                         input logic [31:0] ins, input logic mis);
    chk({tag, "_valid"}, 64'(out_w.valid), 64'(v));
    chk({tag, "_pc"}, out_w.pc, pc);
    chk({tag, "_instr"}, 64'(out_w.raw_instr), 64'(ins));
    chk({tag, "_mis"}, 64'(out_w.misalign), 64'(mis));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_in();
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  function automatic logic [31:0] mem_word(input addr_t a);
    return a[31:0] ^ (a[63:32] * 32'd7) ^ 32'h5A5A_0F0F;
  endfunction

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    idle_in();
    repeat (3) cyc();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_w.valid), 64'd0);
    chk("rst_req_valid", 64'(ireq_valid), 64'd1);
    chk("rst_req_addr", ireq_addr, 64'h8000_0000);

    // Same-cycle addr_ok/data_ok on the first request
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0010_0093;
    cyc(); idle_in();
    chk_out("t1_out", 1'b1, 64'h8000_0000, 32'h0010_0093, 1'b0);
    chk("t1_req_valid", 64'(ireq_valid), 64'd1);
    chk("t1_req_addr", ireq_addr, 64'h8000_0004);

    // Stall: second word lands in the skid and fetching stops
    stall = 1'b1;
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0020_0113;
    cyc(); idle_in();
    chk_out("t2_out", 1'b1, 64'h8000_0000, 32'h0010_0093, 1'b0);
    chk("t2_req_valid", 64'(ireq_valid), 64'd0);
    cyc(); cyc();
    chk_out("t2_hold", 1'b1, 64'h8000_0000, 32'h0010_0093, 1'b0);
    chk("t2_hold_req_valid", 64'(ireq_valid), 64'd0);
    stall = 1'b0;
    cyc();
    chk_out("t2_drain", 1'b1, 64'h8000_0004, 32'h0020_0113, 1'b0);
    chk("t2_drain_req_valid", 64'(ireq_valid), 64'd1);
    chk("t2_drain_req_addr", ireq_addr, 64'h8000_0008);
    cyc();
    chk("t2_empty_valid", 64'(out_w.valid), 64'd0);

    // Redirect in REQ with addr_ok held off: request frozen, response dropped
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    cyc(); idle_in();
    for (int i = 0; i < 3; i++) begin
      chk("t3_req_valid", 64'(ireq_valid), 64'd1);
      chk("t3_req_addr", ireq_addr, 64'h8000_0008);
      chk("t3_out_valid", 64'(out_w.valid), 64'd0);
      if (i < 2) cyc();
    end
    iresp_addr_ok = 1'b1;
    cyc(); idle_in();
    chk("t3_wait_req_valid", 64'(ireq_valid), 64'd0);
    chk("t3_wait_out_valid", 64'(out_w.valid), 64'd0);
    iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
    cyc(); idle_in();
    chk("t3_drop_out_valid", 64'(out_w.valid), 64'd0);
    chk("t3_new_req_valid", 64'(ireq_valid), 64'd1);
    chk("t3_new_req_addr", ireq_addr, 64'h8000_0100);

    // Redirect coincident with data_ok
    iresp_addr_ok = 1'b1;
    cyc(); idle_in();
    iresp_data_ok = 1'b1; iresp_data = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    cyc(); idle_in();
    chk("t4_out_valid", 64'(out_w.valid), 64'd0);
    chk("t4_req_valid", 64'(ireq_valid), 64'd1);
    chk("t4_req_addr", ireq_addr, 64'h8000_0200);
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0030_0193;
    cyc(); idle_in();
    chk_out("t4_after", 1'b1, 64'h8000_0200, 32'h0030_0193, 1'b0);

    // PC wrap at the top of the address space
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h2222_2222;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(); idle_in();
    chk("t5_out_valid", 64'(out_w.valid), 64'd0);
    chk("t5_req_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0040_0213;
    cyc(); idle_in();
    chk_out("t5_wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0040_0213, 1'b0);
    chk("t5_req_valid", 64'(ireq_valid), 64'd1);
    chk("t5_req_addr", ireq_addr, 64'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect target yields a flagged NOP and no bus request
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h3333_3333;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
    cyc(); idle_in();
    chk("t6_req_valid", 64'(ireq_valid), 64'd0);
    chk("t6_out_valid", 64'(out_w.valid), 64'd0);
    cyc();
    chk_out("t6_mis", 1'b1, 64'h8000_0002, 32'h0000_0013, 1'b1);
    chk("t6_mis_req_valid", 64'(ireq_valid), 64'd0);
    cyc();
    chk("t6_parked_out_valid", 64'(out_w.valid), 64'd0);
    chk("t6_parked_req_valid", 64'(ireq_valid), 64'd0);
`endif

    // Randomized run against the instruction-stream model
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_pc = 64'h8000_0000; delivered = 0; outst = 1'b0; ost_addr = '0; dly = 0;
    p_req_v = 1'b0; p_aok = 1'b0; p_rd = 1'b0; p_req_a = '0;
    for (int cy = 0; cy < 4000; cy++) begin
      if (p_rd) chk("rnd_flush", 64'(out_w.valid), 64'd0);
      if (p_req_v && !p_aok) begin
        chk("rnd_hold_valid", 64'(ireq_valid), 64'd1);
        chk("rnd_hold_addr", ireq_addr, p_req_a);
      end
      if (ireq_valid) chk("rnd_one_outstanding", 64'(outst), 64'd0);

      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0:       tgt = 64'hFFFF_FFFF_FFFF_FFF0;
        1:       tgt = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
        default: tgt = {32'($urandom), 32'($urandom)};
      endcase
      tgt[1:0] = 2'b00;
      redirect_pc   = tgt;
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = 32'($urandom);
      if (outst) begin
        if (dly == 0) begin
          iresp_data_ok = 1'b1;
          iresp_data    = mem_word(ost_addr);
        end
      end else if (ireq_valid && ($urandom_range(0, 99) < 60)) begin
        iresp_addr_ok = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          iresp_data_ok = 1'b1;
          iresp_data    = mem_word(ireq_addr);
        end
      end

      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (out_w.valid && !stall) begin
        chk("rnd_pc", out_w.pc, exp_pc);
        chk("rnd_instr", 64'(out_w.raw_instr), 64'(mem_word(exp_pc)));
        chk("rnd_mis", 64'(out_w.misalign), 64'd0);
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end

      p_rd    = redirect_valid;
      p_req_v = ireq_valid;
      p_req_a = ireq_addr;
      p_aok   = iresp_addr_ok;
      if (iresp_data_ok) begin
        outst = 1'b0;
      end else if (iresp_addr_ok) begin
        outst    = 1'b1;
        ost_addr = ireq_addr;
        dly      = $urandom_range(0, 3);
      end else if (outst && dly > 0) begin
        dly--;
      end
      cyc();
    end
    chk("rnd_progress", 64'(delivered >= 150), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
